// File: rtl/pipelined_adder_tree.sv
// pipelined_adder_tree
//   Sums NUM_INPUTS unsigned operands of DATA_WIDTH bits through a registered binary
//   adder tree (one register level per tree level). A valid shift register travels
//   alongside the data. A result that is valid but not taken freezes the whole pipeline.
//
// Parameters
//   DATA_WIDTH  width of each operand
//   NUM_INPUTS  operand count (2, 4, 8 or 16)
//
// Ports
//   ap_clk      clock, rising edge
//   ap_rst      synchronous active-high reset
//   ap_start    operand set valid
//   ap_ready    block can accept an operand set this cycle
//   in_data     flattened operands, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_ready   downstream accepts result
//   ap_done     result valid
//   result      sum of the accepted operand set (DATA_WIDTH+LEVELS bits, never wraps)
//   ap_idle     nothing in flight and nothing offered
//
// Build option
//   ADDER_TREE_INPUT_REG_EN  adds an input register stage ahead of the first adder
//                            level; latency becomes LEVELS+1 instead of LEVELS.

module pipelined_adder_tree #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_INPUTS = 4
) (
    input  logic                                      ap_clk,
    input  logic                                      ap_rst,
    input  logic                                      ap_start,
    output logic                                      ap_ready,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0]          in_data,
    input  logic                                      out_ready,
    output logic                                      ap_done,
    output logic [DATA_WIDTH+$clog2(NUM_INPUTS)-1:0]  result,
    output logic                                      ap_idle
);

    localparam int unsigned LEVELS = $clog2(NUM_INPUTS);
`ifdef ADDER_TREE_INPUT_REG_EN
    localparam int unsigned InReg = 1;
`else
    localparam int unsigned InReg = 0;
`endif
    localparam int unsigned LATENCY = LEVELS + InReg;

    logic               stall;
    logic               accept;
    logic [LATENCY-1:0] vld_q, vld_d;

    // Reset forces ready high and blocks acceptance of anything offered meanwhile.
    assign ap_done  = vld_q[LATENCY-1];
    assign stall    = ap_done & ~out_ready & ~ap_rst;
    assign ap_ready = ~stall;
    assign accept   = ap_start & ap_ready & ~ap_rst;
    assign ap_idle  = ~(|vld_q) & ~ap_start;

    // Valid bits shift only when the pipeline moves; a stall freezes bubbles too.
    always_comb begin
        vld_d = vld_q;
        if (!stall) begin
            vld_d = (vld_q << 1) | LATENCY'(accept);
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Level k holds NUM_INPUTS>>k lanes, each DATA_WIDTH+k bits wide so no sum wraps.
    for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
        localparam int unsigned N = NUM_INPUTS >> k;
        localparam int unsigned W = DATA_WIDTH + k;

        logic [N-1:0][W-1:0] lvl;

        if (k == 0) begin : g_src
`ifdef ADDER_TREE_INPUT_REG_EN
            always_ff @(posedge ap_clk) begin
                if (ap_rst) begin
                    lvl <= '0;
                end else if (!stall && accept) begin
                    lvl <= in_data;
                end
            end
`else
            assign lvl = in_data;
`endif
        end else begin : g_add
            // Index into vld_q of the stage feeding this level; negative means accept.
            localparam int PreIdx = int'(k) + int'(InReg) - 2;

            logic                ld;
            logic [N-1:0][W-1:0] lvl_d;

            if (PreIdx < 0) begin : g_ld_acc
                assign ld = accept;
            end else begin : g_ld_vld
                assign ld = vld_q[PreIdx];
            end

            for (genvar j = 0; j < N; j++) begin : g_lane
                assign lvl_d[j] = W'(g_lvl[k-1].lvl[2*j]) + W'(g_lvl[k-1].lvl[2*j+1]);
            end

            // Load only real data; bubbles leave the previous contents in place.
            always_ff @(posedge ap_clk) begin
                if (ap_rst) begin
                    lvl <= '0;
                end else if (!stall && ld) begin
                    lvl <= lvl_d;
                end
            end
        end
    end

    assign result = g_lvl[LEVELS].lvl;

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Testbench for pipelined_adder_tree (DATA_WIDTH=8, NUM_INPUTS=4).
// Stimulus pushes expected sums into a scoreboard; an independent monitor pops and
// compares whenever ap_done is presented.

module tb_pipelined_adder_tree;

    localparam int DW = 8;
    localparam int NI = 4;
    localparam int LV = 2;
`ifdef ADDER_TREE_INPUT_REG_EN
    localparam int LAT = LV + 1;
`else
    localparam int LAT = LV;
`endif

    logic             clk = 1'b0;
    logic             ap_rst;
    logic             ap_start;
    logic             ap_ready;
    logic [NI*DW-1:0] in_data;
    logic             out_ready;
    logic             ap_done;
    logic [DW+LV-1:0] result;
    logic             ap_idle;

    typedef struct {
        int exp;
        int cyc;
        bit chk;
    } item_t;

    item_t sb[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    last_exp = 0;
    bit    prev_stall = 1'b0;

    pipelined_adder_tree #(
        .DATA_WIDTH(DW),
        .NUM_INPUTS(NI)
    ) dut (
        .ap_clk   (clk),
        .ap_rst   (ap_rst),
        .ap_start (ap_start),
        .ap_ready (ap_ready),
        .in_data  (in_data),
        .out_ready(out_ready),
        .ap_done  (ap_done),
        .result   (result),
        .ap_idle  (ap_idle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Offer one operand set for one cycle; record the expectation only if accepted.
    task automatic send(input int d0, input int d1, input int d2, input int d3,
                        input int exp, input bit push, input bit chk);
        item_t it;
        ap_start = 1'b1;
        in_data  = {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
        @(negedge clk);
        if (ap_ready && push) begin
            it.exp = exp;
            it.cyc = cyc;
            it.chk = chk;
            sb.push_back(it);
        end
        @(posedge clk);
        #1;
        ap_start = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check(name, sb.size(), 0);
        @(negedge clk);
        check({name, "_idle"}, ap_idle, 1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every presented result against the scoreboard head.
    always @(negedge clk) begin
        if (ap_rst) begin
            last_exp   = 0;
            prev_stall = 1'b0;
        end else if (ap_done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", ap_done, 0);
            end else begin
                if (!prev_stall && sb[0].chk) check("latency", cyc - sb[0].cyc, LAT);
                check("result", result, sb[0].exp);
                if (out_ready) begin
                    last_exp = sb[0].exp;
                    void'(sb.pop_front());
                    prev_stall = 1'b0;
                end else begin
                    check("ready_in_stall", ap_ready, 0);
                    prev_stall = 1'b1;
                end
            end
        end else begin
            check("result_hold", result, last_exp);
            prev_stall = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ap_rst    = 1'b1;
        ap_start  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset state, and an offer during reset must not be taken.
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_done", ap_done, 0);
        check("rst_result", result, 0);
        check("rst_ready", ap_ready, 1);
        check("rst_idle", ap_idle, 1);
        ap_start = 1'b1;
        in_data  = {8'd7, 8'd7, 8'd7, 8'd7};
        @(negedge clk);
        check("rst_ready_start", ap_ready, 1);
        check("rst_idle_start", ap_idle, 0);
        @(posedge clk);
        #1;
        ap_rst   = 1'b0;
        ap_start = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Single sets, including the no-wrap maximum.
        send(1, 2, 3, 4, 10, 1, 1);
        drain("single_10");
        send(255, 255, 255, 255, 1020, 1, 1);
        drain("max_1020");
        send(10, 20, 30, 40, 100, 1, 1);
        send(255, 0, 255, 0, 510, 1, 1);
        drain("pair");

        // Back-to-back sets.
        send(1, 1, 1, 1, 4, 1, 1);
        send(2, 2, 2, 2, 8, 1, 1);
        send(3, 3, 3, 3, 12, 1, 1);
        send(128, 1, 64, 2, 195, 1, 1);
        drain("b2b");

        // Two in flight, first result held for 3 cycles; an offer mid-stall is ignored.
        send(1, 1, 2, 2, 6, 1, 1);
        send(3, 3, 4, 4, 14, 1, 0);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        send(50, 50, 50, 50, 200, 1, 0);
        out_ready = 1'b1;
        drain("stall");

        // Reset right after an accept discards the set.
        send(5, 5, 5, 5, 20, 0, 0);
        ap_rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", ap_ready, 1);
        @(posedge clk);
        #1;
        ap_rst = 1'b0;
        @(negedge clk);
        check("mid_rst_done", ap_done, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_idle", ap_idle, 1);
        repeat (6) @(negedge clk);
        check("mid_rst_sb", sb.size(), 0);

        // Normal operation after the mid-flight reset.
        @(posedge clk);
        #1;
        send(9, 8, 7, 6, 30, 1, 1);
        drain("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
